// File: rtl/switch_pkg.sv
// switch_pkg: switch-wide constants, header field positions and arbiter state type
package switch_pkg;
  localparam int NUM_PORTS = 4;
  localparam int DEST_MSB = 31;
  localparam int DEST_LSB = 24;
  localparam int LEN_MSB = 23;
  localparam int LEN_LSB = 8;
  localparam int SEQ_MSB = 7;
  localparam int SEQ_LSB = 0;
  typedef enum logic {ARB_IDLE, ARB_XFER} arb_state_t;
  function automatic logic [LEN_MSB-LEN_LSB:0] hdr_len(input logic [31:0] w);
    return w[LEN_MSB:LEN_LSB];
  endfunction
endpackage

// File: rtl/rr_picker.sv
// rr_picker: picks the first set request at or above i_rr_ptr, wrapping; N must be a power of two
module rr_picker #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_rr_ptr,
  output logic         o_found,
  output logic [W-1:0] o_pick
);
  logic [W-1:0] w_idx;
  // scan from the farthest offset down so the nearest requester wins last
  always_comb begin
    o_found = 1'b0;
    o_pick = '0;
    w_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = i_rr_ptr + W'(k);
      if (i_req[w_idx]) begin
        o_found = 1'b1;
        o_pick = w_idx;
      end
    end
  end
endmodule

// File: rtl/output_port_arbiter.sv
// output_port_arbiter: packet-granular round-robin sharing of one egress port among NUM_IN buffers.
// Define OUTPUT_ARB_STATS_EN to add per-requester completed-packet counters (pkt_count, stats_clr).
module output_port_arbiter
  import switch_pkg::*;
#(
  parameter int NUM_IN = NUM_PORTS,
  parameter int DATA_W = 32,
  parameter int LEN_W = 16,
  localparam int GW = $clog2(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN-1:0]        in_valid,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  output logic [NUM_IN-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready,
  output logic [GW-1:0]            grant_id,
  output logic                     busy
`ifdef OUTPUT_ARB_STATS_EN
  ,
  output logic [NUM_IN*16-1:0]     pkt_count,
  input  logic                     stats_clr
`endif
);
  arb_state_t r_state, w_state_nxt;
  logic [GW-1:0] r_rr_ptr, r_grant_id, w_pick;
  logic [LEN_W-1:0] r_remaining, w_hdr_len;
  logic r_out_valid;
  logic [DATA_W-1:0] r_out_data, w_word;
  logic w_found, w_move, w_accept, w_done;
  logic [DATA_W-1:0] w_words [NUM_IN];
  for (genvar g = 0; g < NUM_IN; g++) begin : g_unpack
    assign w_words[g] = in_data[g*DATA_W +: DATA_W];
  end
  rr_picker #(.N(NUM_IN)) u_pick (
    .i_req   (in_valid),
    .i_rr_ptr(r_rr_ptr),
    .o_found (w_found),
    .o_pick  (w_pick)
  );
  assign w_word = w_words[r_grant_id];
  assign w_hdr_len = LEN_W'(hdr_len(w_word));
  assign w_move = (r_state == ARB_XFER) & (~r_out_valid | out_ready);
  assign w_accept = w_move & in_valid[r_grant_id];
  // remaining==0 while in XFER means the next accepted word is the header
  assign w_done = w_accept & (r_remaining == '0 ? w_hdr_len == '0 : r_remaining == LEN_W'(1));
  assign in_ready = w_move ? NUM_IN'(1) << r_grant_id : '0;
  assign out_valid = r_out_valid;
  assign out_data = r_out_data;
  assign grant_id = r_grant_id;
  assign busy = r_state == ARB_XFER;
  always_comb begin
    w_state_nxt = r_state == ARB_IDLE ? (w_found ? ARB_XFER : ARB_IDLE) : (w_done ? ARB_IDLE : ARB_XFER);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ARB_IDLE;
    else r_state <= w_state_nxt;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr <= '0;
      r_grant_id <= '0;
      r_remaining <= '0;
      r_out_valid <= 1'b0;
      r_out_data <= '0;
    end else begin
      if (r_state == ARB_IDLE && w_found) r_grant_id <= w_pick;
      if (w_done) r_rr_ptr <= r_grant_id + GW'(1);
      if (w_accept) r_remaining <= r_remaining == '0 ? w_hdr_len : r_remaining - LEN_W'(1);
      if (w_accept) r_out_data <= w_word;
      r_out_valid <= w_accept | (r_out_valid & ~out_ready);
    end
  end
`ifdef OUTPUT_ARB_STATS_EN
  logic [15:0] r_pkt_count [NUM_IN];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) for (int k = 0; k < NUM_IN; k++) r_pkt_count[k] <= '0;
    else if (stats_clr) for (int k = 0; k < NUM_IN; k++) r_pkt_count[k] <= '0;
    else if (w_done) r_pkt_count[r_grant_id] <= r_pkt_count[r_grant_id] + 16'd1;
  end
  for (genvar g = 0; g < NUM_IN; g++) begin : g_cnt
    assign pkt_count[g*16 +: 16] = r_pkt_count[g];
  end
`endif
endmodule

// File: doc/output_port_arbiter.md
Name: output_port_arbiter

Overview:
- Shares one switch output port among NUM_IN input daemons, which feed it through their per-output buffers.
- Grants at packet granularity with round-robin fairness.
- Holds a grant from the header word to the last payload word, then re-arbitrates.
- Sits between the per-output buffers and the egress port; one instance per output port.

Parameters:
- NUM_IN, 4, number of requesters; power of two, 2..8.
- DATA_W, 32, word width; header layout assumes 32.
- LEN_W, 16, width of the pkt_length field (header bits [23:8]).

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  reset; asynchronous, active-low (0 = reset).
- in_valid  input  NUM_IN  per-requester word valid.
- in_data  input  NUM_IN*DATA_W  flattened words; requester i at [i*DATA_W +: DATA_W].
- in_ready  output  NUM_IN  per-requester pop; one-hot or zero.
- out_valid  output  1  egress word valid (registered).
- out_data  output  DATA_W  egress word (registered).
- out_ready  input  1  egress backpressure.
- grant_id  output  clog2(NUM_IN)  current or last granted requester.
- busy  output  1  high while in XFER.

Behaviour:
- Packet format:
  - Header word: dest[31:24], pkt_length[23:16..8], seq[7:0].
  - The header is followed by exactly pkt_length payload words, so a packet is pkt_length+1 words.
  - pkt_length=0 means a header-only packet.
- Handshake:
  - A word transfers on in_valid[g] & in_ready[g].
  - in_ready[g] = (state==XFER) & (~out_valid | out_ready).
  - in_ready is 0 for every non-granted requester.
  - An egress word is consumed on out_valid & out_ready.
  - Data and valid on the egress side are held stable while out_valid & ~out_ready.
- Latency: an accepted input word appears on out_data in the following cycle. Full throughput is 1 word/cycle when out_ready stays high.
- State machine:
  - IDLE: if any in_valid, pick the first set bit scanning from rr_ptr upward with wrap. Register the pick in grant_id and go to XFER (one bubble cycle). If no in_valid, stay in IDLE.
  - XFER, first accepted word: treat it as the header and load remaining = pkt_length. If pkt_length=0, the packet completes on this word.
  - XFER, later accepted words: remaining decrements by 1. The packet completes when a word is accepted with remaining==1.
  - On completion: go to IDLE and set rr_ptr = grant_id+1 mod NUM_IN. The next arbitration happens the cycle after completion.
- Counters:
  - remaining is LEN_W bits wide.
  - pkt_length=16'hFFFF is legal: 65536 words total, with no overflow.
- out_valid: set on any accepted word; cleared on an egress consume with no new accept in the same cycle. A simultaneous accept and consume keeps out_valid=1 with the new data.
- Boundary conditions:
  - Granted requester drops in_valid mid-packet: the grant is held, no words move, and there is no timeout.
  - Other requesters asserting valid during XFER: ignored until IDLE.
  - Only one requester valid: it is re-granted after each packet, with a 1-cycle bubble between packets.
  - rr_ptr wraps from NUM_IN-1 to 0.
- Reset (asynchronous, may land mid-packet): state=IDLE, rr_ptr=0, grant_id=0, remaining=0, out_valid=0, out_data=0, busy=0, in_ready=0. A partial packet is dropped, and upstream is responsible for resynchronising.

Optional Feature:
- Macro: OUTPUT_ARB_STATS_EN.
- When defined:
  - Adds output pkt_count (NUM_IN*16 bits). Entry i counts completed packets granted to requester i, 16 bits, wrapping.
  - Adds input stats_clr (1). A synchronous clear of all counters that takes priority over an increment in the same cycle.
  - Counters reset to 0.
- When undefined: neither port nor the counters exist, and behaviour is otherwise identical.

Decomposition:
- Package switch_pkg:
  - NUM_PORTS=4.
  - Header field constants DEST_MSB/LSB=31/24, LEN_MSB/LSB=23/8, SEQ_MSB/LSB=7/0.
  - State enum {ARB_IDLE, ARB_XFER}.
- Sub-module rr_picker:
  - Combinational.
  - Inputs: req vector, rr_ptr.
  - Outputs: found, pick index.
  - Instantiated once; reusable by the other output-port arbiters.

Test Plan:
- Single packet: in_valid=4'b0001, header 32'h01_0003_07 plus 3 payload words, out_ready=1 -> 4 words on out_data in order, each 1 cycle after its accept; in_ready[0] is low in the bubble cycle; back to IDLE; rr_ptr=1.
- Round-robin: all four inputs valid, each sending pkt_length=1 -> grants in order 0,1,2,3,0; no interleaving of words from different packets.
- Backpressure: out_ready toggled 1010 during a 5-word packet -> no word lost or duplicated; out_data stable while stalled; in_ready low whenever out_valid & ~out_ready.
- Header-only packet: pkt_length=0 from input 2 -> exactly one egress word; then IDLE; grant_id=2; next grant starts scanning at 3.
- Mid-packet stall and reset: input 1 drops valid after 2 of 6 words, while input 3 is valid -> grant stays 1 with no egress activity; then assert rst=0 -> all outputs 0, state IDLE; after release, input 3 is granted only once rr_ptr=0 has scanned past the idle inputs (0, 1 and 2 not valid).
- OUTPUT_ARB_STATS_EN defined: 3 packets from input 0 and 1 from input 3 -> pkt_count[0]=3, pkt_count[3]=1; then pulse stats_clr -> all counters 0.
